spi3_responder: RTL and testbench

Responder (slave) end of the 2-bit-per-trit serial link driven by `top`. It receives ternary words on `I_mosi` and returns a word on `O_miso`, clocked by the initiator's `I_sck`, and oversamples everything in the local `I_clk` domain. Received words go to local logic over a valid/ready port, and transmit words come from local logic over a second valid/ready port.

---
 rtl/spi3_responder_if.sv | 25 ++
 rtl/spi3_responder.sv | 151 +++++++++++++++
 tb/tb_spi3_responder.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi3_responder_if.sv
// Link pins of the 2-bit-per-trit serial responder plus its local rx/tx valid/ready ports.
// slave = responder side, master = initiator / local-logic side.
interface spi3_responder_if #(parameter int WORD_TRITS = 9);
    logic [1:0]              I_sck;
    logic [1:0]              I_mosi;
    logic [1:0]              O_miso;
    logic [2*WORD_TRITS-1:0] O_rx_data;
    logic                    O_rx_valid;
    logic                    I_rx_ready;
    logic [2*WORD_TRITS-1:0] I_tx_data;
    logic                    I_tx_valid;
    logic                    O_tx_ready;
    logic                    O_err;
    logic                    O_overrun;

    modport slave (
        input  I_sck, I_mosi, I_rx_ready, I_tx_data, I_tx_valid,
        output O_miso, O_rx_data, O_rx_valid, O_tx_ready, O_err, O_overrun
    );

    modport master (
        output I_sck, I_mosi, I_rx_ready, I_tx_data, I_tx_valid,
        input  O_miso, O_rx_data, O_rx_valid, O_tx_ready, O_err, O_overrun
    );
endinterface

// File: rtl/spi3_responder.sv
// Ternary serial-link responder, oversampled in the local clock domain.
// Optional trailing check trit on both directions when SPI3_CHECK_EN is defined.
module spi3_responder #(
    parameter int WORD_TRITS = 9
) (
    input logic             I_clk,
    input logic             I_rst,
    spi3_responder_if.slave bus
);
    localparam int DW = 2*WORD_TRITS;
`ifdef SPI3_CHECK_EN
    localparam int FRAME = WORD_TRITS + 1;
`else
    localparam int FRAME = WORD_TRITS;
`endif
    localparam int FW = 2*FRAME;
    localparam int CW = $clog2(FRAME+1);

    typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;
    state_t state;

    // Synchronisers and edge history stay unreset so a select held high
    // across reset release is never mistaken for a new frame start.
    logic [1:0] sck_s1, sck_s2, sck_q, mosi_s1, mosi_s2;
    always_ff @(posedge I_clk) begin
        sck_s1  <= bus.I_sck;
        sck_s2  <= sck_s1;
        sck_q   <= sck_s2;
        mosi_s1 <= bus.I_mosi;
        mosi_s2 <= mosi_s1;
    end

    logic sel_rise, sel_fall, sck_rise, sck_fall;
    assign sel_rise = sck_s2[1] & ~sck_q[1];
    assign sel_fall = ~sck_s2[1] & sck_q[1];
    assign sck_rise = sck_s2[0] & ~sck_q[0];
    assign sck_fall = ~sck_s2[0] & sck_q[0];

    logic [CW-1:0]  cnt;
    logic           inv;
    logic [FW-3:0]  rx_sh;
    logic [FW-1:0]  rx_nx, tx_sh, tx_frame;
    logic [DW-1:0]  tx_hold, tx_word, rx_word;
    logic           last, bad, tx_load, tx_take;

`ifdef SPI3_CHECK_EN
    // Mod-3 sum of the trits; the residue 0/1/2 is already the trit code 00/01/10.
    function automatic logic [1:0] chk_trit(input logic [DW-1:0] w);
        logic [1:0] acc;
        acc = 2'd0;
        for (int i = 0; i < WORD_TRITS; i++) begin
            case (w[2*i +: 2])
                2'b01:   acc = (acc == 2'd2) ? 2'd0 : acc + 2'd1;
                2'b10:   acc = (acc == 2'd0) ? 2'd2 : acc - 2'd1;
                default: ;
            endcase
        end
        return acc;
    endfunction
`endif

    assign tx_word = bus.O_tx_ready ? '0 : tx_hold;
    assign rx_nx   = {rx_sh, mosi_s2};
    assign last    = (cnt == CW'(FRAME-1));
    assign tx_load = bus.I_tx_valid & bus.O_tx_ready;
    assign tx_take = (state == IDLE) & sel_rise;

`ifdef SPI3_CHECK_EN
    assign tx_frame = {tx_word, chk_trit(tx_word)};
    assign rx_word  = rx_nx[FW-1:2];
    assign bad      = inv | (mosi_s2 == 2'b11) | (rx_nx[1:0] != chk_trit(rx_nx[FW-1:2]));
`else
    assign tx_frame = tx_word;
    assign rx_word  = rx_nx;
    assign bad      = inv | (mosi_s2 == 2'b11);
`endif

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state          <= IDLE;
            cnt            <= '0;
            inv            <= 1'b0;
            rx_sh          <= '0;
            tx_sh          <= '0;
            tx_hold        <= '0;
            bus.O_miso     <= 2'b11;
            bus.O_rx_data  <= '0;
            bus.O_rx_valid <= 1'b0;
            bus.O_tx_ready <= 1'b1;
            bus.O_err      <= 1'b0;
            bus.O_overrun  <= 1'b0;
        end else begin
            bus.O_err     <= 1'b0;
            bus.O_overrun <= 1'b0;
            if (bus.O_rx_valid && bus.I_rx_ready)
                bus.O_rx_valid <= 1'b0;

            // A same-cycle load wins the ready flag; the frame already took the old contents.
            if (tx_load) begin
                tx_hold        <= bus.I_tx_data;
                bus.O_tx_ready <= 1'b0;
            end else if (tx_take) begin
                bus.O_tx_ready <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (sel_rise) begin
                        state      <= ACTIVE;
                        cnt        <= '0;
                        inv        <= 1'b0;
                        bus.O_miso <= tx_frame[FW-1 -: 2];
                        tx_sh      <= tx_frame << 2;
                    end
                end
                ACTIVE: begin
                    if (sel_fall) begin
                        state      <= IDLE;
                        bus.O_err  <= 1'b1;
                        bus.O_miso <= 2'b11;
                    end else if (sck_rise) begin
                        rx_sh <= rx_nx[FW-3:0];
                        cnt   <= cnt + CW'(1);
                        if (mosi_s2 == 2'b11)
                            inv <= 1'b1;
                        if (last) begin
                            state      <= DONE;
                            bus.O_miso <= 2'b11;
                            if (bad) begin
                                bus.O_err <= 1'b1;
                            end else if (!bus.O_rx_valid || bus.I_rx_ready) begin
                                bus.O_rx_data  <= rx_word;
                                bus.O_rx_valid <= 1'b1;
                            end else begin
                                bus.O_overrun <= 1'b1;
                            end
                        end
                    end else if (sck_fall) begin
                        bus.O_miso <= tx_sh[FW-1 -: 2];
                        tx_sh      <= tx_sh << 2;
                    end
                end
                DONE: begin
                    if (sel_fall)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi3_responder.sv
// Randomised bench for spi3_responder against a frame-level behavioural model.
// Works with or without SPI3_CHECK_EN.
`timescale 1ns/1ps
module tb_spi3_responder;
    localparam int WT = 9;
    localparam int DW = 2*WT;
`ifdef SPI3_CHECK_EN
    localparam int FRAME = WT + 1;
`else
    localparam int FRAME = WT;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi3_responder_if #(.WORD_TRITS(WT)) bus();
    spi3_responder #(.WORD_TRITS(WT)) dut (.I_clk(clk), .I_rst(rst), .bus(bus));

    int tests = 0;
    int fails = 0;

    // Model state
    logic          exp_valid = 1'b0;
    logic [DW-1:0] exp_data = '0;
    logic          exp_tx_full = 1'b0;
    logic [DW-1:0] exp_tx_word = '0;
    int            exp_err = 0, exp_ovr = 0, seen_err = 0, seen_ovr = 0;
    bit            settled = 1'b0;
    logic          prev_err = 1'b0, prev_ovr = 1'b0;
    logic [1:0]    fb  [16];
    logic [1:0]    got [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [1:0] chk_of(input logic [DW-1:0] w);
        int s;
        s = 0;
        for (int i = 0; i < WT; i++) begin
            case (w[2*i +: 2])
                2'b01:   s += 1;
                2'b10:   s -= 1;
                default: ;
            endcase
        end
        s = ((s % 3) + 3) % 3;
        return (s == 0) ? 2'b00 : (s == 1) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [DW-1:0] fb_word();
        logic [DW-1:0] w;
        w = '0;
        for (int i = 0; i < WT; i++) w = {w[DW-3:0], fb[i]};
        return w;
    endfunction

    task automatic set_word(input logic [DW-1:0] w);
        for (int i = 0; i < WT; i++) fb[i] = w[DW-1-2*i -: 2];
        fb[WT] = chk_of(w);
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        logic [1:0]    t;
        w = '0;
        for (int i = 0; i < WT; i++) begin
            t = 2'($urandom_range(0, 2));
            w = {w[DW-3:0], t};
        end
        return w;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Every-cycle compare against the model whenever no transfer is in flight
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.O_err) seen_err++;
            if (bus.O_overrun) seen_ovr++;
            check("err_width", {63'd0, bus.O_err & prev_err}, 64'd0);
            check("ovr_width", {63'd0, bus.O_overrun & prev_ovr}, 64'd0);
            if (settled) begin
                check("rx_valid", bus.O_rx_valid, exp_valid);
                if (exp_valid) check("rx_data", bus.O_rx_data, exp_data);
                check("tx_ready", bus.O_tx_ready, !exp_tx_full);
                check("miso_idle", bus.O_miso, 2'b11);
            end
        end
        prev_err = bus.O_err;
        prev_ovr = bus.O_overrun;
    end

    task automatic send(input int n, input int rst_at);
        logic [DW-1:0] txw, w;
        logic [1:0]    er;
        bit            rst_hit, bad;
        settled = 1'b0;
        rst_hit = 1'b0;
        txw = exp_tx_full ? exp_tx_word : '0;
        exp_tx_full = 1'b0;
        bus.I_sck = 2'b10;
        tick(6);
        check("tx_ready_start", bus.O_tx_ready, 1'b1);
        for (int i = 0; i < n; i++) begin
            if (i == rst_at) begin
                rst = 1'b1;
                tick(2);
                check("rst_miso", bus.O_miso, 2'b11);
                check("rst_rx_data", bus.O_rx_data, '0);
                check("rst_rx_valid", bus.O_rx_valid, 1'b0);
                check("rst_tx_ready", bus.O_tx_ready, 1'b1);
                check("rst_err", bus.O_err, 1'b0);
                check("rst_ovr", bus.O_overrun, 1'b0);
                rst = 1'b0;
                exp_valid = 1'b0;
                exp_data = '0;
                exp_tx_full = 1'b0;
                rst_hit = 1'b1;
            end
            bus.I_mosi = fb[i];
            tick(5);
            got[i] = bus.O_miso;
            bus.I_sck = 2'b11;
            tick(5);
            bus.I_sck = 2'b10;
        end
        tick(5);
        bus.I_sck = 2'b00;
        tick(8);
        if (!rst_hit) begin
            for (int i = 0; i < n; i++) begin
                er = (i < WT) ? txw[DW-1-2*i -: 2] : chk_of(txw);
                check("miso_trit", got[i], er);
            end
            if (n < FRAME) begin
                exp_err++;
            end else begin
                w = fb_word();
                bad = 1'b0;
                for (int i = 0; i < FRAME; i++) if (fb[i] == 2'b11) bad = 1'b1;
                if (FRAME > WT && fb[WT] != chk_of(w)) bad = 1'b1;
                if (bad) exp_err++;
                else if (exp_valid) exp_ovr++;
                else begin
                    exp_valid = 1'b1;
                    exp_data = w;
                end
            end
        end
        check("err_count", seen_err, exp_err);
        check("ovr_count", seen_ovr, exp_ovr);
        settled = 1'b1;
        tick(2);
    endtask

    task automatic pop();
        settled = 1'b0;
        bus.I_rx_ready = 1'b1;
        tick(1);
        bus.I_rx_ready = 1'b0;
        exp_valid = 1'b0;
        tick(1);
        settled = 1'b1;
    endtask

    task automatic load_tx(input logic [DW-1:0] w);
        settled = 1'b0;
        bus.I_tx_data = w;
        bus.I_tx_valid = 1'b1;
        tick(1);
        bus.I_tx_valid = 1'b0;
        if (!exp_tx_full) begin
            exp_tx_full = 1'b1;
            exp_tx_word = w;
        end
        tick(1);
        check("tx_ready_load", bus.O_tx_ready, 1'b0);
        settled = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] wa, wb, wr;
        int n;
        bus.I_sck = 2'b00;
        bus.I_mosi = 2'b00;
        bus.I_rx_ready = 1'b0;
        bus.I_tx_data = '0;
        bus.I_tx_valid = 1'b0;
        rst = 1'b1;
        tick(4);
        check("init_miso", bus.O_miso, 2'b11);
        check("init_rx_data", bus.O_rx_data, '0);
        check("init_rx_valid", bus.O_rx_valid, 1'b0);
        check("init_tx_ready", bus.O_tx_ready, 1'b1);
        check("init_err", bus.O_err, 1'b0);
        check("init_ovr", bus.O_overrun, 1'b0);
        rst = 1'b0;
        settled = 1'b1;
        tick(3);

        // Pin the model's check-trit arithmetic
        check("model_chk_a", chk_of(18'b01_01_01_00_00_00_00_00_00), 2'b00);
        check("model_chk_b", chk_of(18'b01_10_00_00_00_00_00_00_01), 2'b01);
        check("model_chk_c", chk_of(18'b10_00_00_00_00_00_00_00_00), 2'b10);

        // Basic frame, nothing loaded for tx
        set_word(18'b01_10_00_00_00_00_00_00_01);
        send(FRAME, -1);
        check("t1_rx_data", bus.O_rx_data, 18'b01_10_00_00_00_00_00_00_01);
        check("t1_rx_valid", bus.O_rx_valid, 1'b1);
        check("t1_miso_first", got[0], 2'b00);
        check("t1_miso_last", got[WT-1], 2'b00);
        pop();

        // Tx word returned on miso
        load_tx(18'b10_00_00_00_00_00_00_00_01);
        set_word(rand_word());
        send(FRAME, -1);
        check("t2_miso_first", got[0], 2'b10);
        check("t2_miso_last", got[WT-1], 2'b01);
        pop();

        // Overrun: second word dropped, first kept
        wa = 18'b01_01_00_10_00_01_00_00_10;
        wb = 18'b10_10_10_00_01_00_00_01_00;
        set_word(wa);
        send(FRAME, -1);
        set_word(wb);
        send(FRAME, -1);
        check("t3_kept", bus.O_rx_data, wa);
        check("t3_ovr", seen_ovr, 1);
        pop();

        // Abort after 4 trits, then a clean frame
        set_word(rand_word());
        send(4, -1);
        check("t4_no_valid", bus.O_rx_valid, 1'b0);
        wr = rand_word();
        set_word(wr);
        send(FRAME, -1);
        check("t4_next", bus.O_rx_data, wr);
        pop();

        // Invalid trit mid-word
        set_word(rand_word());
        fb[3] = 2'b11;
        send(FRAME, -1);
        check("t5_no_valid", bus.O_rx_valid, 1'b0);

`ifdef SPI3_CHECK_EN
        // Wrong check trit
        set_word(rand_word());
        fb[WT] = (fb[WT] == 2'b00) ? 2'b01 : 2'b00;
        send(FRAME, -1);
        check("t6_bad_chk", bus.O_rx_valid, 1'b0);
`endif

        // Reset in the middle of a frame, then a clean frame
        load_tx(rand_word());
        set_word(rand_word());
        send(FRAME, 4);
        wr = rand_word();
        set_word(wr);
        send(FRAME, -1);
        check("t7_after_rst", bus.O_rx_data, wr);
        pop();

        // Randomised traffic
        for (int k = 0; k < 24; k++) begin
            if (!exp_tx_full && ($urandom_range(0, 2) == 0)) load_tx(rand_word());
            set_word(rand_word());
            if ($urandom_range(0, 15) == 0) fb[$urandom_range(0, FRAME-1)] = 2'b11;
            n = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, FRAME-1)) : FRAME;
            send(n, -1);
            if ($urandom_range(0, 1) == 0) pop();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
